instr_fetch: RTL and testbench

Instruction fetch stage for the Lab B processor. It owns the program counter (PC) and the instruction register (IR), and drives the address of the synchronous instruction ROM. It sits directly upstream of the controller: it obeys the controller's `PC_clr`, `PC_up` and `IR_ld` strobes and delivers the 16-bit `instruction` word the controller decodes. It also absorbs the ROM's one-cycle read latency, so the controller never decodes stale data.

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 107 ++++++++++
 tb/tb_instr_fetch.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: controller strobes, ROM port and IR/PC results.
// The slave modport is the fetch stage; master is the controller/ROM side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
) ();
  logic              PC_clr;
  logic              PC_up;
  logic              IR_ld;
  logic [DATA_W-1:0] imem_rdata;
  logic [ADDR_W-1:0] imem_addr;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              stall;

  modport master (
    output PC_clr, PC_up, IR_ld, imem_rdata,
    input  imem_addr, PC, instruction, ir_pc, ir_valid, stall
  );

  modport slave (
    input  PC_clr, PC_up, IR_ld, imem_rdata,
    output imem_addr, PC, instruction, ir_pc, ir_valid, stall
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns PC and IR, hides the one-cycle ROM latency
// by deferring IR loads issued before the ROM word for PC has arrived.
module instr_fetch #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.slave   bus
);
  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_PEND  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              stall_q, stall_d;
  logic              inc_pend_q, inc_pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      stall_q    <= 1'b0;
      inc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      stall_q    <= stall_d;
      inc_pend_q <= inc_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    inc_pend_d = inc_pend_q;

    if (bus.PC_clr) begin
      state_d    = ST_WAIT;
      pc_d       = '0;
      ir_d       = '0;
      ir_pc_d    = '0;
      ir_valid_d = 1'b0;
      inc_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          // ROM word for PC not back yet: defer a load, keep PC steady for it
          if (bus.IR_ld) begin
            state_d    = ST_PEND;
            inc_pend_d = bus.PC_up;
          end else if (bus.PC_up) begin
            pc_d = pc_q + ADDR_W'(1);
          end else begin
            state_d = ST_READY;
          end
        end
        ST_PEND: begin
          ir_d       = bus.imem_rdata;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          if (inc_pend_q) begin
            pc_d       = pc_q + ADDR_W'(1);
            inc_pend_d = 1'b0;
            state_d    = ST_WAIT;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (bus.IR_ld) begin
            ir_d       = bus.imem_rdata;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
          end
          if (bus.PC_up) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end

    stall_d = (state_d == ST_PEND);
  end

  assign bus.imem_addr   = pc_q;
  assign bus.PC          = pc_q;
  assign bus.instruction = ir_q;
  assign bus.ir_pc       = ir_pc_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.stall       = stall_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random strobes against a
// reference model that loads straight from the ROM array.
module tb_instr_fetch;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  instr_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] rom [128];
  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  // reference: "fresh" means the ROM output already reflects the current PC
  logic [AW-1:0] m_pc, m_irpc;
  logic [DW-1:0] m_ir;
  logic          m_valid, m_pend, m_inc, m_fresh;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("pc",       32'(bus.PC),          32'(m_pc));
    chk("addr",     32'(bus.imem_addr),   32'(m_pc));
    chk("instr",    32'(bus.instruction), 32'(m_ir));
    chk("ir_pc",    32'(bus.ir_pc),       32'(m_irpc));
    chk("ir_valid", 32'(bus.ir_valid),    32'(m_valid));
    chk("stall",    32'(bus.stall),       32'(m_pend));
  endtask

  task automatic model_step(input logic r, input logic c, input logic u, input logic l);
    if (r || c) begin
      m_pc = '0; m_ir = '0; m_irpc = '0; m_valid = 1'b0;
      m_pend = 1'b0; m_inc = 1'b0; m_fresh = 1'b0;
    end else if (m_pend) begin
      m_ir = rom[m_pc]; m_irpc = m_pc; m_valid = 1'b1; m_pend = 1'b0;
      if (m_inc) begin
        m_pc = m_pc + 7'd1; m_inc = 1'b0; m_fresh = 1'b0;
      end else begin
        m_fresh = 1'b1;
      end
    end else if (!m_fresh) begin
      if (l) begin
        m_pend = 1'b1; m_inc = u;
      end else if (u) begin
        m_pc = m_pc + 7'd1;
      end else begin
        m_fresh = 1'b1;
      end
    end else begin
      if (l) begin
        m_ir = rom[m_pc]; m_irpc = m_pc; m_valid = 1'b1;
      end
      if (u) begin
        m_pc = m_pc + 7'd1; m_fresh = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic u, input logic l);
    rst = r; bus.PC_clr = c; bus.PC_up = u; bus.IR_ld = l;
    @(posedge clk);
    model_step(r, c, u, l);
    @(negedge clk);
    chk_model();
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = DW'($urandom);
    rom[0]   = 16'h2104;
    rom[1]   = 16'h3123;
    rom[127] = 16'h5000;
    rst = 1'b1; bus.PC_clr = 1'b0; bus.PC_up = 1'b0; bus.IR_ld = 1'b0;

    // reset then idle
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_pc",    32'(bus.PC), 32'h0);
    chk("rst_instr", 32'(bus.instruction), 32'h0);
    chk("rst_valid", 32'(bus.ir_valid), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    cyc(0, 0, 0, 0);
    chk("idle_stall", 32'(bus.stall), 32'h0);

    // fetch+increment from READY, then a stalled fetch
    cyc(0, 0, 1, 1);
    chk("fi_instr", 32'(bus.instruction), 32'h2104);
    chk("fi_irpc",  32'(bus.ir_pc), 32'h0);
    chk("fi_pc",    32'(bus.PC), 32'h1);
    cyc(0, 0, 0, 1);
    chk("fi_stall", 32'(bus.stall), 32'h1);
    cyc(0, 0, 0, 0);
    chk("fi2_instr", 32'(bus.instruction), 32'h3123);
    chk("fi2_irpc",  32'(bus.ir_pc), 32'h1);
    chk("fi2_stall", 32'(bus.stall), 32'h0);

    // deferred increment at PC=5
    cyc(1, 0, 0, 0);
    ups(5);
    cyc(0, 0, 1, 1);
    chk("di_pc",    32'(bus.PC), 32'h5);
    chk("di_stall", 32'(bus.stall), 32'h1);
    cyc(0, 0, 0, 0);
    chk("di_instr", 32'(bus.instruction), 32'(rom[5]));
    chk("di_pc2",   32'(bus.PC), 32'h6);
    cyc(0, 0, 0, 1);
    chk("di_wait",  32'(bus.stall), 32'h1);

    // wrap-around 127 -> 0
    cyc(1, 0, 0, 0);
    ups(127);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    chk("wr_instr", 32'(bus.instruction), 32'h5000);
    chk("wr_pc",    32'(bus.PC), 32'h0);
    chk("wr_valid", 32'(bus.ir_valid), 32'h1);
    chk("wr_stall", 32'(bus.stall), 32'h0);

    // clear during PEND at PC=9
    cyc(1, 0, 0, 0);
    ups(9);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("cp_pend", 32'(bus.stall), 32'h0);
    cyc(1, 0, 0, 0);
    ups(9);
    cyc(0, 0, 1, 1);
    chk("cp_stall0", 32'(bus.stall), 32'h1);
    cyc(0, 1, 0, 0);
    chk("cp_pc",    32'(bus.PC), 32'h0);
    chk("cp_instr", 32'(bus.instruction), 32'h0);
    chk("cp_valid", 32'(bus.ir_valid), 32'h0);
    chk("cp_stall", 32'(bus.stall), 32'h0);

    // reset beats strobes at PC=40
    cyc(1, 0, 0, 0);
    ups(40);
    cyc(1, 0, 1, 1);
    chk("rp_pc",    32'(bus.PC), 32'h0);
    chk("rp_instr", 32'(bus.instruction), 32'h0);
    cyc(0, 0, 0, 1);
    chk("rp_wait",  32'(bus.stall), 32'h1);

    // random strobes
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(15) == 0),
          1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
